elevator_scan_ctrl: RTL
=======================

ELEVATOR_SCAN_CTRL -- requirements
Module: elevator_scan_ctrl

Interface
REQ-001 SHALL have parameter N_FLOORS, default 8, number of floors (2..16).
REQ-002 SHALL have parameter TRAVEL_TICKS, default 4, tick pulses per floor-to-floor move (>=1).
REQ-003 SHALL have parameter DOOR_TICKS, default 6, tick pulses the door stays open (>=1).
REQ-004 SHALL have port CLK  input  1  rising-edge clock.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port tick  input  1  one-cycle timebase pulse from the slow divider.
REQ-007 SHALL have port call_req  input  N_FLOORS  level floor-call buttons, bit i = floor i.
REQ-008 SHALL have port hold  input  1  emergency hold, stops travel and keeps the door open.
REQ-009 SHALL have port floor  output  FW=$clog2(N_FLOORS)  current floor, registered.
REQ-010 SHALL have port dir  output  1  1 = up, 0 = down; last travel direction.
REQ-011 SHALL have port run  output  1  car in motion.
REQ-012 SHALL have port door_open  output  1  door open.
REQ-013 SHALL have port hold_active  output  1  in HOLD state.
REQ-014 SHALL have port pending  output  N_FLOORS  latched, unserved calls.
REQ-015 SHALL have port state_value  output  3  current state encoding, for display.

Function
REQ-016 SHALL implement states RST, IDLE, UP, DN, HOLD, ARRIVE, DOOR.
REQ-017 SHALL set pending[i] on any cycle call_req[i]=1; setting beats clearing on the same cycle only for floors other than the current floor.
REQ-018 SHALL clear pending[floor] on the cycle it enters DOOR.
REQ-019 IDLE: pending[floor] -> DOOR; else calls in dir beyond floor -> that direction; else calls on the opposite side -> reverse dir and move; else stay IDLE.
REQ-020 UP/DN: run=1; count tick pulses; on the TRAVEL_TICKSth pulse, floor+/-1, counter cleared, -> ARRIVE.
REQ-021 ARRIVE (1 cycle, run=0): pending[floor] -> DOOR; else calls beyond in dir -> continue same direction; else -> IDLE.
REQ-022 DOOR: door_open=1; count tick pulses; after DOOR_TICKS pulses -> IDLE; call_req[floor]=1 or hold=1 during DOOR restarts the door count.
REQ-023 hold=1 in UP/DN -> HOLD next cycle; travel counter frozen; run=0, hold_active=1.
REQ-024 HOLD with hold=0 -> resume UP or DN per dir with the retained counter value.
REQ-025 hold SHALL be ignored in IDLE and ARRIVE.
REQ-026 floor SHALL never go below 0 or above N_FLOORS-1; no move begins toward a boundary without a pending call beyond it.
REQ-027 Unused state encodings -> RST next cycle.
REQ-028 All outputs SHALL be registered or decoded from registered state only; no input-to-output combinational path.

Reset
REQ-029 reset=1 -> RST on the next edge; floor=0, dir=1, run=0, door_open=0, hold_active=0, pending=0, all counters 0.
REQ-030 RST -> IDLE unconditionally after one cycle; reset SHALL override a move, hold or open door in progress.

Structure
REQ-031 Package elevator_pkg SHALL hold the state enum (3-bit, RST=3'b100, IDLE=3'b000) and the FW width function.
REQ-032 One sub-module tick_counter (load/clear, enable, terminal-count flag, parameter TERMINAL) SHALL be instantiated for travel and for door timing.
REQ-033 The above/below-call search SHALL be a combinational mask-compare of pending against a floor-derived thermometer mask.

Verification (N_FLOORS=8, TRAVEL_TICKS=2, DOOR_TICKS=3, tick=1 every cycle)
REQ-034 Reset, call_req[5] pulsed 1 cycle -> UP; floor reaches 5 after 10 travel cycles, then DOOR for 3 cycles; pending[5] clears; then IDLE.
REQ-035 At floor 5, call_req = 8'b1000_0010 -> serves floor 7 first (dir=1), then reverses and serves floor 1.
REQ-036 hold=1 for 5 cycles mid-travel -> run=0, hold_active=1, floor steady; after release, arrival occurs exactly 5 cycles later than nominal.
REQ-037 call_req[floor] during DOOR -> door_open extends 3 ticks past the last press; pending stays 0.
REQ-038 reset asserted mid-travel at floor 3 -> next cycle RST, floor=0, pending=0, run=0.
REQ-039 At floor 0 with no calls -> stays IDLE, run=0, floor never underflows; same check at floor 7 for overflow.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared types for the SCAN elevator controller: state encoding and the
// floor-index width helper.
package elevator_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'b000,
        ST_UP     = 3'b001,
        ST_DN     = 3'b010,
        ST_HOLD   = 3'b011,
        ST_RST    = 3'b100,
        ST_ARRIVE = 3'b101,
        ST_DOOR   = 3'b110
    } state_t;

    // Floor index width; a two-floor car still needs one bit.
    function automatic int fw(input int n);
        return (n > 2) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/elevator_scan_ctrl_tick_counter.sv
// Tick-pulse counter with clear, enable and a terminal-count flag that is
// raised on the TERMINALth enabled pulse; the count wraps to zero there.
module tick_counter #(
    parameter int TERMINAL = 4
) (
    input  logic CLK,
    input  logic reset,
    input  logic clear,
    input  logic en,
    output logic tc
);
    localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;
    localparam logic [CW-1:0] LAST = CW'(TERMINAL - 1);

    logic [CW-1:0] count;

    assign tc = en && (count == LAST);

    always_ff @(posedge CLK) begin
        if (reset || clear) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/elevator_scan_ctrl.sv
// SCAN (elevator-algorithm) car controller: latches floor calls, keeps
// travelling in one direction while calls remain beyond the car, then reverses.
module elevator_scan_ctrl
    import elevator_pkg::*;
#(
    parameter int N_FLOORS     = 8,
    parameter int TRAVEL_TICKS = 4,
    parameter int DOOR_TICKS   = 6
) (
    input  logic                    CLK,
    input  logic                    reset,
    input  logic                    tick,
    input  logic [N_FLOORS-1:0]     call_req,
    input  logic                    hold,
    output logic [fw(N_FLOORS)-1:0] floor,
    output logic                    dir,
    output logic                    run,
    output logic                    door_open,
    output logic                    hold_active,
    output logic [N_FLOORS-1:0]     pending,
    output logic [2:0]              state_value
);
    localparam int FW = fw(N_FLOORS);
    localparam logic [FW-1:0] TOP_FLOOR = FW'(N_FLOORS - 1);

    state_t              state, next_state;
    logic [FW-1:0]       next_floor;
    logic                next_dir;
    logic [N_FLOORS-1:0] next_pending;
    logic [N_FLOORS-1:0] at_mask, below_mask, above_mask, clr_mask, keep_mask;
    logic                calls_above, calls_below, calls_fwd, calls_back, pend_here;
    logic                in_travel, travel_clear, travel_en, travel_tc;
    logic                in_door, door_restart, door_clear, door_en, door_tc;
    logic                entering_door;

    // One-hot of the current floor; subtracting one yields the thermometer
    // of every floor below it.
    always_comb begin
        at_mask        = '0;
        at_mask[floor] = 1'b1;
    end

    assign below_mask  = at_mask - N_FLOORS'(1);
    assign above_mask  = ~(below_mask | at_mask);
    assign calls_above = |(pending & above_mask);
    assign calls_below = |(pending & below_mask);
    assign pend_here   = |(pending & at_mask);
    assign calls_fwd   = dir ? calls_above : calls_below;
    assign calls_back  = dir ? calls_below : calls_above;

    assign in_travel    = (state == ST_UP) || (state == ST_DN);
    assign travel_clear = !(in_travel || (state == ST_HOLD));
    assign travel_en    = in_travel & tick;

    assign in_door      = (state == ST_DOOR);
    assign door_restart = in_door & ((|(call_req & at_mask)) | hold);
    assign door_clear   = ~in_door | door_restart;
    assign door_en      = in_door & tick & ~door_restart;

    tick_counter #(.TERMINAL(TRAVEL_TICKS)) u_travel (
        .CLK   (CLK),
        .reset (reset),
        .clear (travel_clear),
        .en    (travel_en),
        .tc    (travel_tc)
    );

    tick_counter #(.TERMINAL(DOOR_TICKS)) u_door (
        .CLK   (CLK),
        .reset (reset),
        .clear (door_clear),
        .en    (door_en),
        .tc    (door_tc)
    );

    always_comb begin
        next_state = state;
        next_floor = floor;
        next_dir   = dir;
        case (state)
            ST_RST: next_state = ST_IDLE;
            ST_IDLE: begin
                if (pend_here) begin
                    next_state = ST_DOOR;
                end else if (calls_fwd) begin
                    next_state = dir ? ST_UP : ST_DN;
                end else if (calls_back) begin
                    next_dir   = ~dir;
                    next_state = dir ? ST_DN : ST_UP;
                end
            end
            ST_UP, ST_DN: begin
                // Arrival wins over hold; hold is then caught on the next leg.
                if (travel_tc) begin
                    next_state = ST_ARRIVE;
                    if (state == ST_UP && floor != TOP_FLOOR) begin
                        next_floor = floor + 1'b1;
                    end else if (state == ST_DN && floor != '0) begin
                        next_floor = floor - 1'b1;
                    end
                end else if (hold) begin
                    next_state = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (!hold) begin
                    next_state = dir ? ST_UP : ST_DN;
                end
            end
            ST_ARRIVE: begin
                if (pend_here) begin
                    next_state = ST_DOOR;
                end else if (calls_fwd) begin
                    next_state = dir ? ST_UP : ST_DN;
                end else begin
                    next_state = ST_IDLE;
                end
            end
            ST_DOOR: begin
                if (door_tc) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_RST;
        endcase
    end

    // A press at the floor being served is absorbed by the open door rather
    // than latched, so it never re-triggers a service cycle.
    assign entering_door = (next_state == ST_DOOR) && !in_door;
    assign clr_mask      = entering_door ? at_mask : '0;
    assign keep_mask     = (in_door || entering_door) ? ~at_mask : '1;
    assign next_pending  = (pending & ~clr_mask) | (call_req & keep_mask);

    always_ff @(posedge CLK) begin
        if (reset) begin
            state   <= ST_RST;
            floor   <= '0;
            dir     <= 1'b1;
            pending <= '0;
        end else begin
            state   <= next_state;
            floor   <= next_floor;
            dir     <= next_dir;
            pending <= next_pending;
        end
    end

    assign run         = in_travel;
    assign door_open   = in_door;
    assign hold_active = (state == ST_HOLD);
    assign state_value = state;

endmodule
